wide_add_sequencer: RTL and testbench

WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

---
 rtl/wide_add_sequencer_pkg.sv | 13 +
 rtl/wide_add_sequencer_byte_add_slice.sv | 20 ++
 rtl/wide_add_sequencer.sv | 136 +++++++++++++
 tb/tb_wide_add_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wide_add_sequencer_pkg.sv
// Shared types and constants for the byte-serial wide adder/subtractor.
package wide_add_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int NBYTES_MIN = 2;
  localparam int NBYTES_MAX = 16;

endpackage

// File: rtl/wide_add_sequencer_byte_add_slice.sv
// Combinational 8-bit add slice: s = a + b + ci, with the carry out of bit 7
// and the carry into bit 7 (needed for signed overflow on the top byte).
module byte_add_slice (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co,
  output logic       cmsb
);

  logic [8:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {8'd0, ci};
  assign s    = full[7:0];
  assign co   = full[8];
  // Carry into bit 7 recovered from the sum bit and its two operand bits.
  assign cmsb = s[7] ^ a[7] ^ b[7];

endmodule

// File: rtl/wide_add_sequencer.sv
// Byte-serial add/subtract sequencer: one byte per cycle, LSB first, through a
// single shared byte_add_slice.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and a producer holds its payload stable
// until the transfer edge.
import wide_add_sequencer_pkg::*;

module wide_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  ovf,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  generate
    if (NBYTES < NBYTES_MIN || NBYTES > NBYTES_MAX) begin : g_bad_nbytes
      $error("wide_add_sequencer: NBYTES out of range");
    end
  endgenerate

  seq_state_t    state_q;
  logic [CW-1:0] k_q;
  logic          carry_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          cout_q;
  logic          ovf_q;
  logic          out_valid_q;
  logic          in_ready_q;
  logic          busy_q;

  logic [CW+2:0] bit_idx;
  logic [7:0]    sl_a;
  logic [7:0]    sl_b;
  logic [7:0]    sl_s;
  logic          sl_co;
  logic          sl_cmsb;

  assign bit_idx = {k_q, 3'b000};
  assign sl_a    = a_q[bit_idx +: 8];
  assign sl_b    = b_q[bit_idx +: 8];

  byte_add_slice u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .ci   (carry_q),
    .s    (sl_s),
    .co   (sl_co),
    .cmsb (sl_cmsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Subtract is A + ~B + 1, so the slice only ever adds.
            a_q        <= a;
            b_q        <= sub ? ~b : b;
            carry_q    <= sub ? 1'b1 : cin;
            k_q        <= '0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q[bit_idx +: 8] <= sl_s;
          carry_q             <= sl_co;
          if (k_q == LAST) begin
            cout_q      <= sl_co;
            ovf_q       <= sl_cmsb ^ sl_co;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            k_q <= k_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer (NBYTES=4): directed table,
// randomized ops against an arithmetic model, and multi-cycle corner cases.
module tb_wide_add_sequencer;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;
  logic [1:0]   dbg_state;

  int checks;
  int errors;

  // Expected results, packed as {cout, ovf, sum}.
  logic [W+1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;
  } vec_t;

  wide_add_sequencer #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the full-width operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub);
    longint ua, ub, ur, sa, sb, sr;
    logic c, o;
    ua = longint'({32'd0, ma});
    ub = longint'({32'd0, mb});
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (msub) begin
      ur = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      ur = ua + ub + longint'(mcin);
      c  = (ur >= 64'sh1_0000_0000);
      sr = sa + sb + longint'(mcin);
    end
    o = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
    return {c, o, ur[W-1:0]};
  endfunction

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check({name, "_ready_timeout"}, 64'(in_ready), 64'd1);
  endtask

  // Driver: one full transaction, checked against exp_q front.
  task automatic do_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vcin, input logic vsub);
    int lat;
    logic [W+1:0] e;
    wait_ready(name);
    a = va; b = vb; cin = vcin; sub = vsub;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, "_busy"}, 64'(busy), 64'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      check({name, "_upper_zero"}, 64'(sum >> (8 * lat)), 64'd0);
      @(posedge clk); #1;
      lat++;
    end
    // NB slice cycles after the accept edge (NB+1 edges counting the accept edge).
    check({name, "_latency"}, 64'(lat), 64'(NB));
    e = exp_q.pop_front();
    check({name, "_sum"}, 64'(sum), 64'(e[W-1:0]));
    check({name, "_cout"}, 64'(cout), 64'(e[W+1]));
    check({name, "_ovf"}, 64'(ovf), 64'(e[W]));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_idle_after"}, 64'({in_ready, out_valid}), 64'b10);
  endtask

  vec_t vecs[6];

  initial begin
    logic [W-1:0] ra, rb, hold_sum;
    logic         rc, rs;
    logic         hold_cout, hold_ovf;
    int           cyc, acc_cyc, hs_cyc, n_acc, n_hs;
    logic [W+1:0] e;
    logic         pre_acc, pre_hs;

    checks = 0; errors = 0;
    in_valid = 0; out_ready = 0; a = '0; b = '0; cin = 0; sub = 0;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0101, 1'b0, 1'b0};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_vals", 64'({sum, cout, ovf, out_valid, busy, dbg_state}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({vecs[i].e_cout, vecs[i].e_ovf, vecs[i].e_sum});
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
    end

    // Randomized against the model
    for (int i = 0; i < 20; i++) begin
      ra = $urandom(); rb = $urandom();
      if (i % 5 == 0) rb = ra;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      exp_q.push_back(model(ra, rb, rc, rs));
      do_op($sformatf("rand%0d", i), ra, rb, rc, rs);
    end

    // Backpressure: stall 10 cycles with a competing request
    wait_ready("bp");
    a = 32'h0000_FFFF; b = 32'h0000_0001; cin = 0; sub = 0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("bp_reach_done", 64'(out_valid), 64'd1);
    hold_sum = sum; hold_cout = cout; hold_ovf = ovf;
    check("bp_sum", 64'(sum), 64'h0001_0000);
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; sub = 1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_stall%0d", i),
            64'({out_valid, in_ready, cout, ovf, sum}),
            64'({1'b1, 1'b0, hold_cout, hold_ovf, hold_sum}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release", 64'({in_ready, out_valid}), 64'b10);
    repeat (NB + 2) @(posedge clk);
    #1;
    check("bp_no_ghost_accept", 64'({in_ready, out_valid, busy}), 64'b100);

    // Reset during the 2nd RUN cycle
    wait_ready("mr");
    a = 32'h0F0F_0F0F; b = 32'h0101_0101; cin = 0; sub = 0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mr_partial", 64'(sum), 64'h0000_0010);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mr_cleared", 64'({dbg_state, sum, out_valid, in_ready}), 64'({2'd0, 32'd0, 1'b0, 1'b1}));
    for (int i = 0; i < NB + 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("mr_no_valid%0d", i), 64'(out_valid), 64'd0);
    end

    // Back-to-back with in_valid and out_ready held high
    exp_q.delete();
    a = 32'h0000_0005; b = 32'h0000_0003; cin = 0; sub = 1;
    exp_q.push_back(model(a, b, cin, sub));
    in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0; acc_cyc = -1; hs_cyc = -1; n_acc = 0; n_hs = 0;
    while (n_hs < 2 && cyc < 40) begin
      pre_acc = in_valid && in_ready;
      pre_hs  = out_valid && out_ready;
      if (pre_hs) begin
        e = exp_q.pop_front();
        check($sformatf("b2b_result%0d", n_hs), 64'({cout, ovf, sum}), 64'(e));
      end
      @(posedge clk); #1;
      cyc++;
      if (pre_hs) begin
        n_hs++;
        if (n_hs == 1) hs_cyc = cyc;
      end
      if (pre_acc) begin
        n_acc++;
        if (n_acc == 1) begin
          a = 32'hFFFF_0000; b = 32'h0001_0000; cin = 1; sub = 0;
          exp_q.push_back(model(a, b, cin, sub));
        end else begin
          acc_cyc = cyc;
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    check("b2b_handshakes", 64'(n_hs), 64'd2);
    check("b2b_accept_gap", 64'(acc_cyc - hs_cyc), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
